fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads, buffers {pc,instr} pairs in a small FIFO for the decoder.
// Optional FETCH_STATS_EN adds fetch_count / stall_count performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      inf_pc;
    logic             inf;
    logic             kill;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             pop_c;
    logic             push_c;
    logic             grant_c;
    logic [OCC_W-1:0] occ_c;

    // Occupancy counts the in-flight slot so a grant can never overflow the FIFO.
    always_comb begin
        out_valid = (count != '0);
        pop_c     = out_valid & out_ready;
        push_c    = inf & ~kill;
        occ_c     = OCC_W'(count) + OCC_W'(inf) - OCC_W'(pop_c);
        imem_req  = ~reset & ~redirect & (occ_c < OCC_W'(DEPTH));
        grant_c   = imem_req & imem_gnt;
        imem_addr = fetch_pc;
        out_pc    = out_valid ? pc_mem[head]    : 32'h0;
        out_instr = out_valid ? instr_mem[head] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[tail]    <= inf_pc;
            instr_mem[tail] <= imem_rdata;
        end
    end

    // Redirect flushes the buffer; a same-cycle pop is already consumed by the decoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            inf_pc   <= 32'h0;
            inf      <= 1'b0;
            kill     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inf <= grant_c;
            if (grant_c) begin
                inf_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                kill     <= inf | grant_c;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                kill <= 1'b0;
                if (grant_c) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push_c) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop_c) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            fetch_count <= fetch_count + 32'(pop_c);
            stall_count <= stall_count + 32'(imem_req & ~imem_gnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for streaming/stall, hand sequences for redirect and reset corners.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_gnt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        imem_req,  w_imem_req;
    logic [31:0] imem_addr, w_imem_addr;
    logic [31:0] imem_rdata, w_imem_rdata;
    logic        out_valid, w_out_valid;
    logic [31:0] out_instr, w_out_instr;
    logic [31:0] out_pc,    w_out_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_ready(out_ready)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_gnt(imem_gnt), .imem_rdata(w_imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .out_valid(w_out_valid), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .out_ready(out_ready)
`ifdef FETCH_STATS_EN
        , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
    );

    // Memory model: data = address + 0x100, one cycle after a grant.
    logic        pend, w_pend, gclr;
    logic [31:0] paddr, w_paddr;
    int          gcnt;
    always @(posedge clk) begin
        pend    <= imem_req & imem_gnt;
        paddr   <= imem_addr;
        w_pend  <= w_imem_req & imem_gnt;
        w_paddr <= w_imem_addr;
        if (gclr) gcnt <= 0;
        else if (imem_req && imem_gnt) gcnt <= gcnt + 1;
    end
    assign imem_rdata   = pend   ? paddr   + 32'h100 : 32'hDEAD_BEEF;
    assign w_imem_rdata = w_pend ? w_paddr + 32'h100 : 32'hDEAD_BEEF;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic r, input logic g, input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        reset = r; imem_gnt = g; out_ready = rdy; redirect = rd; redirect_pc = rpc;
        gclr = r;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        chk_w;
        logic [31:0] wpc;
        logic [31:0] winstr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h000, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h000, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h100, 1'b1, 32'hFFFF_FFF8, 32'hF8};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h104, 1'b1, 32'hFFFF_FFFC, 32'hFC};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h108, 1'b1, 32'h0000_0000, 32'h100};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 32'h10C, 1'b0, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 32'h10C, 1'b0, 32'h0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 32'h10C, 1'b0, 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 32'h10C, 1'b0, 32'h0, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h10C, 1'b0, 32'h0, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 32'h110, 1'b0, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h114, 1'b0, 32'h0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18, 32'h118, 1'b0, 32'h0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h1C, 32'h11C, 1'b0, 32'h0, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00, 32'h000, 1'b0, 32'h0, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h20, 32'h120, 1'b0, 32'h0, 32'h0};

        reset = 1'b1; imem_gnt = 1'b0; out_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; gclr = 1'b1;

        // Reset state
        do_reset();
        chk("rst req",   32'(imem_req),  32'h0);
        chk("rst addr",  imem_addr,      32'h0);
        chk("rst valid", 32'(out_valid), 32'h0);
        chk("rst pc",    out_pc,         32'h0);
        chk("rst instr", out_instr,      32'h0);
        chk("rst waddr", w_imem_addr,    32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
        chk("rst fcnt", fetch_count, 32'h0);
        chk("rst scnt", stall_count, 32'h0);
`endif

        // Streaming, backpressure, bubble, empty-with-ready
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, tbl[i].gnt, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("t%0d req", i),   32'(imem_req),  32'(tbl[i].req));
            chk($sformatf("t%0d addr", i),  imem_addr,      tbl[i].addr);
            chk($sformatf("t%0d valid", i), 32'(out_valid), 32'(tbl[i].valid));
            chk($sformatf("t%0d pc", i),    out_pc,         tbl[i].pc);
            chk($sformatf("t%0d instr", i), out_instr,      tbl[i].instr);
            if (tbl[i].chk_w) begin
                chk($sformatf("t%0d wrap pc", i),    w_out_pc,    tbl[i].wpc);
                chk($sformatf("t%0d wrap instr", i), w_out_instr, tbl[i].winstr);
            end
        end

        // Decoder stalled from reset: two grants, then no requests
        do_reset();
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall req", 32'(imem_req), 32'h0);
        chk("stall grants", 32'(gcnt), 32'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel pc0", out_pc, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel pc4", out_pc, 32'h4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel pc8", out_pc, 32'h8);
        chk("rel instr8", out_instr, 32'h108);

        // Redirect while a response is in flight, then back-to-back redirects
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("pre redir pc", out_pc, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0403);
        chk("redir req", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir addr", imem_addr, 32'h400);
        chk("redir req1", 32'(imem_req), 32'h1);
        chk("redir flush", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir stale", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir pc", out_pc, 32'h400);
        chk("redir instr", out_instr, 32'h500);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2002);
        chk("b2b req", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b addr", imem_addr, 32'h2000);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b pc", out_pc, 32'h2000);
        chk("b2b instr", out_instr, 32'h2100);

        // Grant pattern 1,0,0,1
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("gp addr0", imem_addr, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("gp req1", 32'(imem_req), 32'h1);
        chk("gp addr1", imem_addr, 32'h4);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("gp addr2", imem_addr, 32'h4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("gp addr3", imem_addr, 32'h4);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("gp addr4", imem_addr, 32'h8);
`ifdef FETCH_STATS_EN
        chk("gp stall_count", stall_count, 32'd2);
        chk("gp fetch_count", fetch_count, 32'd1);
`endif

        // Reset while full, with a concurrent redirect
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("full valid", 32'(out_valid), 32'h1);
        chk("full req", 32'(imem_req), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mrst valid", 32'(out_valid), 32'h0);
        chk("mrst req", 32'(imem_req), 32'h0);
        chk("mrst addr", imem_addr, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst first req", 32'(imem_req), 32'h1);
        chk("mrst first addr", imem_addr, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst pc", out_pc, 32'h0);
        chk("mrst instr", out_instr, 32'h100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
